// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: widths, opcodes, flag layout,
// the EX/MEM payload struct and the per-opcode flag-set mask.
package ex_stage_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned FLAG_W     = 3;
    localparam int unsigned SHAMT_W    = 4;

    localparam logic [OP_W-1:0] OP_ADD    = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB    = 4'h1;
    localparam logic [OP_W-1:0] OP_XOR    = 4'h2;
    localparam logic [OP_W-1:0] OP_RED    = 4'h3;
    localparam logic [OP_W-1:0] OP_SLL    = 4'h4;
    localparam logic [OP_W-1:0] OP_SRA    = 4'h5;
    localparam logic [OP_W-1:0] OP_ROR    = 4'h6;
    localparam logic [OP_W-1:0] OP_PADDSB = 4'h7;
    localparam logic [OP_W-1:0] OP_LW     = 4'h8;
    localparam logic [OP_W-1:0] OP_SW     = 4'h9;
    localparam logic [OP_W-1:0] OP_LLB    = 4'hA;
    localparam logic [OP_W-1:0] OP_LHB    = 4'hB;
    localparam logic [OP_W-1:0] OP_B      = 4'hC;
    localparam logic [OP_W-1:0] OP_BR     = 4'hD;
    localparam logic [OP_W-1:0] OP_PCS    = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT    = 4'hF;

    // Bit positions inside the {Z,V,N} flag register
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    // EX/MEM pipeline register contents
    typedef struct packed {
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  pcs;
        logic                  halt;
        logic [DATA_W-1:0]     pc_inc;
    } ex_mem_t;

    // Which flags an opcode is allowed to update
    function automatic logic [FLAG_W-1:0] flag_mask(input logic [OP_W-1:0] op);
        logic [FLAG_W-1:0] m;
        m = '0;
        case (op)
            OP_ADD, OP_SUB:                 m = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
            default:                        m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// D/EX -> EX and EX/MEM -> MEM signal bundle for the execute stage.
// slave: the execute stage (consumes D/EX + MEM/WB, drives *_out).
// master: the upstream/downstream environment.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic                  in_valid;
    logic                  stall;
    logic                  flush;
    logic                  alu_src;
    logic [OP_W-1:0]       alu_op;
    logic [DATA_W-1:0]     read_data1;
    logic [DATA_W-1:0]     read_data2;
    logic [DATA_W-1:0]     immediate;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  pcs;
    logic                  halt;
    logic [DATA_W-1:0]     pc_inc;
    logic                  memwb_reg_write;
    logic [REG_ADDR_W-1:0] memwb_rd;
    logic [DATA_W-1:0]     memwb_data;

    logic [DATA_W-1:0]     alu_result_out;
    logic [DATA_W-1:0]     store_data_out;
    logic [REG_ADDR_W-1:0] rd_out;
    logic                  mem_read_out;
    logic                  mem_write_out;
    logic                  reg_write_out;
    logic                  mem_to_reg_out;
    logic                  pcs_out;
    logic                  halt_out;
    logic [DATA_W-1:0]     pc_inc_out;
    logic [FLAG_W-1:0]     flags_out;

    modport slave (
        input  in_valid, stall, flush, alu_src, alu_op, read_data1, read_data2,
               immediate, rs, rt, rd, mem_read, mem_write, reg_write, mem_to_reg,
               pcs, halt, pc_inc, memwb_reg_write, memwb_rd, memwb_data,
        output alu_result_out, store_data_out, rd_out, mem_read_out, mem_write_out,
               reg_write_out, mem_to_reg_out, pcs_out, halt_out, pc_inc_out, flags_out
    );

    modport master (
        output in_valid, stall, flush, alu_src, alu_op, read_data1, read_data2,
               immediate, rs, rt, rd, mem_read, mem_write, reg_write, mem_to_reg,
               pcs, halt, pc_inc, memwb_reg_write, memwb_rd, memwb_data,
        input  alu_result_out, store_data_out, rd_out, mem_read_out, mem_write_out,
               reg_write_out, mem_to_reg_out, pcs_out, halt_out, pc_inc_out, flags_out
    );

endinterface

// File: rtl/ex_stage_alu16.sv
// Combinational 16-bit ALU.
// Ports: op (opcode), a (rs operand), b (operand B), shamt (shift amount)
//        -> result, z/v/n candidate flags.
module alu16
    import ex_stage_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  result,
    output logic               z,
    output logic               v,
    output logic               n
);

    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   diff;
    logic [DATA_W-1:0]   paddsb;
    logic [2*DATA_W-1:0] rot;
    logic [9:0]          red;
    logic [3:0]          na, nb, ns;

    always_comb begin
        sum    = a + b;
        diff   = a - b;
        rot    = {a, a} >> shamt;
        red    = {{2{a[15]}}, a[15:8]} + {{2{a[7]}}, a[7:0]}
               + {{2{b[15]}}, b[15:8]} + {{2{b[7]}}, b[7:0]};
        paddsb = '0;
        na     = '0;
        nb     = '0;
        ns     = '0;
        // Per-nibble signed saturating add
        for (int i = 0; i < 4; i++) begin
            na = a[4*i +: 4];
            nb = b[4*i +: 4];
            ns = na + nb;
            if (na[3] == nb[3] && ns[3] != na[3]) ns = na[3] ? 4'h8 : 4'h7;
            paddsb[4*i +: 4] = ns;
        end

        result = '0;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum;
                if (a[15] == b[15] && sum[15] != a[15]) begin
                    result = a[15] ? 16'h8000 : 16'h7FFF;
                    v      = 1'b1;
                end
            end
            OP_SUB: begin
                result = diff;
                if (a[15] != b[15] && diff[15] != a[15]) begin
                    result = a[15] ? 16'h8000 : 16'h7FFF;
                    v      = 1'b1;
                end
            end
            OP_XOR:       result = a ^ b;
            OP_RED:       result = {{6{red[9]}}, red};
            OP_SLL:       result = a << shamt;
            OP_SRA:       result = DATA_W'($signed(a) >>> shamt);
            OP_ROR:       result = rot[DATA_W-1:0];
            OP_PADDSB:    result = paddsb;
            OP_LW, OP_SW: result = (a & 16'hFFFE) + b;
            OP_LLB:       result = (a & 16'hFF00) | {8'h00, b[7:0]};
            OP_LHB:       result = (a & 16'h00FF) | {b[7:0], 8'h00};
            default:      result = '0;
        endcase
        z = (result == '0);
        n = result[15];
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, {Z,V,N} flag register and the
// EX/MEM pipeline register.
// Ports: clk, rst (sync, active-high), bus (ex_stage_if.slave) carrying the
// D/EX inputs, MEM/WB forwarding source and all registered *_out signals.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);

    ex_mem_t           q;
    ex_mem_t           nxt;
    ex_mem_t           bubble;
    logic [FLAG_W-1:0] flags;
    logic [FLAG_W-1:0] mask;
    logic [FLAG_W-1:0] alu_flags;
    logic [DATA_W-1:0] fwd_rs, fwd_rt, op_b, alu_res;
    logic              exmem_ok, memwb_ok;
    logic              z, v, n;

    // Forwarding: EX/MEM has priority over MEM/WB; r0 is never forwarded.
    // Uses the held EX/MEM contents, so a stall loses nothing.
    always_comb begin
        exmem_ok = q.reg_write & ~q.mem_read & (q.rd != '0);
        memwb_ok = bus.memwb_reg_write & (bus.memwb_rd != '0);

        fwd_rs = bus.read_data1;
        if (memwb_ok && bus.memwb_rd == bus.rs) fwd_rs = bus.memwb_data;
        if (exmem_ok && q.rd == bus.rs)         fwd_rs = q.alu_result;

        fwd_rt = bus.read_data2;
        if (memwb_ok && bus.memwb_rd == bus.rt) fwd_rt = bus.memwb_data;
        if (exmem_ok && q.rd == bus.rt)         fwd_rt = q.alu_result;

        op_b = bus.alu_src ? bus.immediate : fwd_rt;
    end

    alu16 u_alu (
        .op     (bus.alu_op),
        .a      (fwd_rs),
        .b      (op_b),
        .shamt  (bus.immediate[SHAMT_W-1:0]),
        .result (alu_res),
        .z      (z),
        .v      (v),
        .n      (n)
    );

    // Next EX/MEM contents for a real instruction and for a bubble
    always_comb begin
        nxt            = '0;
        nxt.alu_result = (bus.alu_op == OP_PCS) ? bus.pc_inc : alu_res;
        nxt.store_data = fwd_rt;
        nxt.rd         = bus.rd;
        nxt.mem_read   = bus.mem_read;
        nxt.mem_write  = bus.mem_write;
        nxt.reg_write  = bus.reg_write;
        nxt.mem_to_reg = bus.mem_to_reg;
        nxt.pcs        = bus.pcs;
        nxt.halt       = bus.halt | q.halt;
        nxt.pc_inc     = bus.pc_inc;

        // halt is sticky until reset, even across bubbles
        bubble         = '0;
        bubble.halt    = q.halt;

        mask      = flag_mask(bus.alu_op);
        alu_flags = '0;
        alu_flags[FLAG_Z] = z;
        alu_flags[FLAG_V] = v;
        alu_flags[FLAG_N] = n;
    end

    // EX/MEM register and flags: rst > flush > stall > capture
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            flags <= '0;
        end else if (bus.flush) begin
            q     <= bubble;
        end else if (!bus.stall) begin
            if (bus.in_valid) begin
                q     <= nxt;
                flags <= (flags & ~mask) | (alu_flags & mask);
            end else begin
                q     <= bubble;
            end
        end
    end

    assign bus.alu_result_out = q.alu_result;
    assign bus.store_data_out = q.store_data;
    assign bus.rd_out         = q.rd;
    assign bus.mem_read_out   = q.mem_read;
    assign bus.mem_write_out  = q.mem_write;
    assign bus.reg_write_out  = q.reg_write;
    assign bus.mem_to_reg_out = q.mem_to_reg;
    assign bus.pcs_out        = q.pcs;
    assign bus.halt_out       = q.halt;
    assign bus.pc_inc_out     = q.pc_inc;
    assign bus.flags_out      = flags;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    ex_stage_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.alu_src = 1'b0; bus.alu_op = OP_B;
        bus.read_data1 = '0; bus.read_data2 = '0; bus.immediate = '0;
        bus.rs = '0; bus.rt = '0; bus.rd = '0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.reg_write = 1'b0;
        bus.mem_to_reg = 1'b0; bus.pcs = 1'b0; bus.halt = 1'b0;
        bus.pc_inc = '0;
        bus.memwb_reg_write = 1'b0; bus.memwb_rd = '0; bus.memwb_data = '0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] rd, input logic [15:0] r1, input logic [15:0] r2,
                         input logic [15:0] imm, input logic asrc, input logic rw,
                         input logic mr, input logic mw);
        bus.in_valid = 1'b1; bus.alu_op = op;
        bus.rs = rs; bus.rt = rt; bus.rd = rd;
        bus.read_data1 = r1; bus.read_data2 = r2; bus.immediate = imm;
        bus.alu_src = asrc; bus.reg_write = rw; bus.mem_read = mr; bus.mem_write = mw;
        bus.mem_to_reg = mr; bus.pcs = 1'b0; bus.halt = 1'b0; bus.pc_inc = 16'h0100;
    endtask

    task automatic test_reset();
        logic [5:0] ctl;
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.alu_src = 1'($urandom); bus.alu_op = 4'($urandom);
        bus.read_data1 = 16'($urandom); bus.read_data2 = 16'($urandom);
        bus.immediate = 16'($urandom);
        bus.rs = 4'($urandom); bus.rt = 4'($urandom); bus.rd = 4'($urandom);
        bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.reg_write = 1'b1;
        bus.mem_to_reg = 1'b1; bus.pcs = 1'b1; bus.halt = 1'b1;
        bus.pc_inc = 16'($urandom);
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 4'($urandom); bus.memwb_data = 16'($urandom);
        tick(); tick();
        ctl = {bus.mem_read_out, bus.mem_write_out, bus.reg_write_out,
               bus.mem_to_reg_out, bus.pcs_out, bus.halt_out};
        n_total++;
        if (bus.alu_result_out !== 16'h0000) $display("FAIL reset_result: got %h expected 0000", bus.alu_result_out);
        else n_pass++;
        n_total++;
        if (bus.store_data_out !== 16'h0000 || bus.pc_inc_out !== 16'h0000 || bus.rd_out !== 4'h0)
            $display("FAIL reset_data: got %h/%h/%h expected 0000/0000/0", bus.store_data_out, bus.pc_inc_out, bus.rd_out);
        else n_pass++;
        n_total++;
        if (ctl !== 6'b000000) $display("FAIL reset_ctl: got %b expected 000000", ctl);
        else n_pass++;
        n_total++;
        if (bus.flags_out !== 3'b000) $display("FAIL reset_flags: got %b expected 000", bus.flags_out);
        else n_pass++;
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_add_sub();
        issue(OP_ADD, 4'd2, 4'd3, 4'd1, 16'h7000, 16'h2000, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h7FFF) $display("FAIL add_sat_result: got %h expected 7fff", bus.alu_result_out);
        else n_pass++;
        n_total++;
        if (bus.flags_out !== 3'b010) $display("FAIL add_sat_flags: got %b expected 010", bus.flags_out);
        else n_pass++;
        issue(OP_SUB, 4'd4, 4'd5, 4'd6, 16'h0005, 16'h0005, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h0000 || bus.flags_out !== 3'b100)
            $display("FAIL sub_zero: got %h/%b expected 0000/100", bus.alu_result_out, bus.flags_out);
        else n_pass++;
    endtask

    task automatic test_forward();
        issue(OP_ADD, 4'd2, 4'd3, 4'd1, 16'h0003, 16'h0004, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        // r2 = r1 + r1 with stale register-file values
        issue(OP_ADD, 4'd1, 4'd1, 4'd2, 16'h0000, 16'h0000, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h000E) $display("FAIL fwd_exmem: got %h expected 000e", bus.alu_result_out);
        else n_pass++;
        // r2 in both EX/MEM (000E) and MEM/WB (1111)
        issue(OP_ADD, 4'd2, 4'd5, 4'd3, 16'h0000, 16'h0001, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 4'd2; bus.memwb_data = 16'h1111;
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h000F) $display("FAIL fwd_priority: got %h expected 000f", bus.alu_result_out);
        else n_pass++;
        bus.memwb_reg_write = 1'b0;
        issue(OP_ADD, 4'd4, 4'd4, 4'd0, 16'h0002, 16'h0003, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        // rd=0 in EX/MEM and in MEM/WB must not forward
        issue(OP_ADD, 4'd0, 4'd0, 4'd6, 16'h0010, 16'h0020, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 4'd0; bus.memwb_data = 16'hFFFF;
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h0030) $display("FAIL fwd_r0: got %h expected 0030", bus.alu_result_out);
        else n_pass++;
        issue(OP_ADD, 4'd9, 4'd10, 4'd7, 16'h0000, 16'h0001, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.memwb_rd = 4'd9; bus.memwb_data = 16'h0100;
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h0101) $display("FAIL fwd_memwb: got %h expected 0101", bus.alu_result_out);
        else n_pass++;
        bus.memwb_reg_write = 1'b0; bus.memwb_rd = '0; bus.memwb_data = '0;
    endtask

    task automatic test_logic_ops();
        issue(OP_ADD, 4'd2, 4'd3, 4'd8, 16'h8000, 16'h8000, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h8000 || bus.flags_out !== 3'b011)
            $display("FAIL add_negsat: got %h/%b expected 8000/011", bus.alu_result_out, bus.flags_out);
        else n_pass++;
        issue(OP_XOR, 4'd4, 4'd5, 4'd9, 16'h1234, 16'h1234, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h0000 || bus.flags_out !== 3'b111)
            $display("FAIL xor_zero: got %h/%b expected 0000/111", bus.alu_result_out, bus.flags_out);
        else n_pass++;
        issue(OP_PADDSB, 4'd6, 4'd7, 4'd10, 16'h7777, 16'h1111, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h7777 || bus.flags_out !== 3'b111)
            $display("FAIL paddsb: got %h/%b expected 7777/111", bus.alu_result_out, bus.flags_out);
        else n_pass++;
        issue(OP_SLL, 4'd2, 4'd3, 4'd1, 16'h0001, 16'h0, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h0010 || bus.flags_out !== 3'b011)
            $display("FAIL sll: got %h/%b expected 0010/011", bus.alu_result_out, bus.flags_out);
        else n_pass++;
        issue(OP_ROR, 4'd5, 4'd6, 4'd4, 16'h0001, 16'h0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h8000) $display("FAIL ror: got %h expected 8000", bus.alu_result_out);
        else n_pass++;
        issue(OP_RED, 4'd6, 4'd7, 4'd2, 16'h7F7F, 16'h7F7F, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h01FC) $display("FAIL red_pos: got %h expected 01fc", bus.alu_result_out);
        else n_pass++;
        issue(OP_RED, 4'd8, 4'd9, 4'd3, 16'h8080, 16'h8080, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'hFE00 || bus.flags_out !== 3'b011)
            $display("FAIL red_neg: got %h/%b expected fe00/011", bus.alu_result_out, bus.flags_out);
        else n_pass++;
    endtask

    task automatic test_stall_flush();
        issue(OP_ADD, 4'd4, 4'd5, 4'd11, 16'h0001, 16'h0002, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h0003 || bus.flags_out !== 3'b000)
            $display("FAIL pre_stall: got %h/%b expected 0003/000", bus.alu_result_out, bus.flags_out);
        else n_pass++;
        // dependent instruction waits under stall
        issue(OP_ADD, 4'd11, 4'd11, 4'd12, 16'h0000, 16'h0000, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (bus.alu_result_out !== 16'h0003 || bus.rd_out !== 4'd11 || bus.flags_out !== 3'b000)
                $display("FAIL stall_hold[%0d]: got %h/%h/%b expected 0003/b/000",
                         i, bus.alu_result_out, bus.rd_out, bus.flags_out);
            else n_pass++;
        end
        bus.stall = 1'b0;
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h0006 || bus.rd_out !== 4'd12)
            $display("FAIL stall_release: got %h/%h expected 0006/c", bus.alu_result_out, bus.rd_out);
        else n_pass++;
        issue(OP_ADD, 4'd1, 4'd2, 4'd13, 16'h0000, 16'h0000, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        bus.stall = 1'b1; bus.flush = 1'b1;
        tick();
        n_total++;
        if ({bus.reg_write_out, bus.mem_read_out, bus.mem_write_out} !== 3'b000 || bus.flags_out !== 3'b000)
            $display("FAIL flush_stall: got ctl %b flags %b expected 000/000",
                     {bus.reg_write_out, bus.mem_read_out, bus.mem_write_out}, bus.flags_out);
        else n_pass++;
        bus.stall = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic test_mem_bubble_halt();
        issue(OP_SW, 4'd1, 4'd2, 4'd0, 16'h1001, 16'hABCD, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h1004 || bus.store_data_out !== 16'hABCD || bus.mem_write_out !== 1'b1)
            $display("FAIL sw: got %h/%h/%b expected 1004/abcd/1",
                     bus.alu_result_out, bus.store_data_out, bus.mem_write_out);
        else n_pass++;
        issue(OP_PCS, 4'd3, 4'd4, 4'd5, 16'h0000, 16'h0000, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.pcs = 1'b1; bus.pc_inc = 16'h0042;
        tick();
        n_total++;
        if (bus.alu_result_out !== 16'h0042 || bus.pcs_out !== 1'b1 || bus.pc_inc_out !== 16'h0042)
            $display("FAIL pcs: got %h/%b/%h expected 0042/1/0042",
                     bus.alu_result_out, bus.pcs_out, bus.pc_inc_out);
        else n_pass++;
        // bubble carrying an ADD that would set Z
        issue(OP_ADD, 4'd6, 4'd7, 4'd8, 16'h0000, 16'h0000, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        n_total++;
        if (bus.flags_out !== 3'b000 || bus.reg_write_out !== 1'b0)
            $display("FAIL bubble: got flags %b rw %b expected 000/0", bus.flags_out, bus.reg_write_out);
        else n_pass++;
        issue(OP_HLT, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.halt = 1'b1;
        tick();
        idle();
        tick();
        n_total++;
        if (bus.halt_out !== 1'b1) $display("FAIL halt_sticky: got %b expected 1", bus.halt_out);
        else n_pass++;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        idle();
        test_reset();
        test_add_sub();
        test_forward();
        test_logic_ops();
        test_stall_flush();
        test_mem_bubble_halt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
